mul_sequencer: RTL and testbench

- Hardware sequencer for the program-3 workload: 16 pairs of signed 16-bit operands in data memory, each multiplied to a signed 32-bit product, products written back to data memory.
- Sits beside the data memory on the top-level start/done handshake.
- Owns the memory port for the whole run and drives an iterative radix-2 Booth multiplier sub-module.
- Storage is big-endian: the MSB byte is at the lower address.

---
 rtl/mul_seq_pkg.sv | 41 ++++
 rtl/booth_mul16.sv | 53 +++++
 rtl/mul_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the program-3 multiply sequencer.
// The Booth step helper is used by the iterative multiplier.
package mul_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_AH    = 4'd1,
        ST_RD_AL    = 4'd2,
        ST_RD_BH    = 4'd3,
        ST_RD_BL    = 4'd4,
        ST_MUL_GO   = 4'd5,
        ST_MUL_WAIT = 4'd6,
        ST_WR0      = 4'd7,
        ST_WR1      = 4'd8,
        ST_WR2      = 4'd9,
        ST_WR3      = 4'd10,
        ST_NEXT     = 4'd11,
        ST_DONE     = 4'd12
    } state_t;

    localparam int PAIR_STRIDE = 4;
    localparam int PROD_STRIDE = 4;
    localparam int MUL_CYCLES  = 16;

    // One radix-2 Booth iteration on {acc[15:0], q[15:0], q_-1}. The add/sub is
    // 17 bits wide so that subtracting -32768 cannot overflow before the shift.
    function automatic logic [32:0] booth_step(input logic [32:0] work, input logic [15:0] m);
        logic [16:0] acc_x;
        logic [16:0] m_x;
        logic [16:0] sum;
        acc_x = {work[32], work[32:17]};
        m_x   = {m[15], m};
        case (work[1:0])
            2'b10:   sum = acc_x - m_x;
            2'b01:   sum = acc_x + m_x;
            default: sum = acc_x;
        endcase
        return {sum, work[16:2], work[1]};
    endfunction

endpackage

// File: rtl/booth_mul16.sv
// Iterative signed 16x16 radix-2 Booth multiplier; 16 cycles from mul_start
// to the one-cycle mul_valid pulse. prod holds until the next mul_start.
module booth_mul16
    import mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mul_start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] prod,
    output logic        mul_valid
);

    logic [32:0] r_work;
    logic [15:0] r_m;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_valid;

    // The first iteration is folded into the load edge so the last one lands
    // on the 16th edge, letting mul_valid line up with the caller's wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work  <= 33'd0;
            r_m     <= 16'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else if (mul_start) begin
            r_work  <= booth_step({16'd0, b, 1'b0}, a);
            r_m     <= a;
            r_cnt   <= 5'(MUL_CYCLES - 1);
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
        end else if (r_busy) begin
            r_work <= booth_step(r_work, r_m);
            r_cnt  <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign prod      = r_work[32:1];
    assign mul_valid = r_valid;

endmodule

// File: rtl/mul_sequencer.sv
// Start/done sequencer: reads 16-bit operand pairs big-endian from data memory,
// multiplies them on booth_mul16 and writes the 32-bit products back.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int NUM_PAIRS = 16,
    parameter int OPND_BASE = 0,
    parameter int PROD_BASE = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [7:0]        dm_rd_data,
    output logic              dm_wr_en,
    output logic [7:0]        dm_wr_data
);

    localparam int J_W = $clog2(NUM_PAIRS) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [J_W-1:0]    r_j;
    logic [J_W-1:0]    w_j_nxt;
    logic              r_start_q;
    logic [15:0]       r_a;
    logic [15:0]       r_b;
    logic              w_mul_start;
    logic              w_mul_valid;
    logic [31:0]       w_prod;
    logic              r_done;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wr_data;
    logic              w_done_nxt;
    logic              w_wr_en_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_wr_data_nxt;
    logic [ADDR_W-1:0] w_opnd_addr;
    logic [ADDR_W-1:0] w_prod_addr;

    assign w_mul_start = (r_state == ST_MUL_GO);

    booth_mul16 u_mul (
        .clk       (clk),
        .reset     (reset),
        .mul_start (w_mul_start),
        .a         (r_a),
        .b         (r_b),
        .prod      (w_prod),
        .mul_valid (w_mul_valid)
    );

    // State, pair index and the registered memory-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_j       <= '0;
            r_start_q <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_j       <= w_j_nxt;
            r_start_q <= start;
            r_done    <= w_done_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // Operand byte capture while the matching read address is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= 16'd0;
            r_b <= 16'd0;
        end else begin
            case (r_state)
                ST_RD_AH: r_a[15:8] <= dm_rd_data;
                ST_RD_AL: r_a[7:0]  <= dm_rd_data;
                ST_RD_BH: r_b[15:8] <= dm_rd_data;
                ST_RD_BL: r_b[7:0]  <= dm_rd_data;
                default:  ;
            endcase
        end
    end

    // Next state; a high start outside IDLE aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != ST_IDLE && start) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nxt = (r_start_q && !start) ? ST_RD_AH : ST_IDLE;
                ST_RD_AH:    w_state_nxt = ST_RD_AL;
                ST_RD_AL:    w_state_nxt = ST_RD_BH;
                ST_RD_BH:    w_state_nxt = ST_RD_BL;
                ST_RD_BL:    w_state_nxt = ST_MUL_GO;
                ST_MUL_GO:   w_state_nxt = ST_MUL_WAIT;
                ST_MUL_WAIT: w_state_nxt = w_mul_valid ? ST_WR0 : ST_MUL_WAIT;
                ST_WR0:      w_state_nxt = ST_WR1;
                ST_WR1:      w_state_nxt = ST_WR2;
                ST_WR2:      w_state_nxt = ST_WR3;
                ST_WR3:      w_state_nxt = ST_NEXT;
                ST_NEXT:     w_state_nxt = (r_j == J_W'(NUM_PAIRS - 1)) ? ST_DONE : ST_RD_AH;
                ST_DONE:     w_state_nxt = ST_DONE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so the registered copies
    // line up with the state they belong to.
    always_comb begin
        if (w_state_nxt == ST_IDLE) begin
            w_j_nxt = '0;
        end else if (r_state == ST_NEXT) begin
            w_j_nxt = r_j + J_W'(1);
        end else begin
            w_j_nxt = r_j;
        end
        w_opnd_addr   = ADDR_W'(OPND_BASE + int'(w_j_nxt) * PAIR_STRIDE);
        w_prod_addr   = ADDR_W'(PROD_BASE + int'(w_j_nxt) * PROD_STRIDE);
        w_done_nxt    = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_addr_nxt    = '0;
        w_wr_data_nxt = 8'd0;
        case (w_state_nxt)
            ST_RD_AH: w_addr_nxt = w_opnd_addr;
            ST_RD_AL: w_addr_nxt = w_opnd_addr + ADDR_W'(1);
            ST_RD_BH: w_addr_nxt = w_opnd_addr + ADDR_W'(2);
            ST_RD_BL: w_addr_nxt = w_opnd_addr + ADDR_W'(3);
            ST_WR0: begin
                w_wr_en_nxt   = 1'b1;
                w_addr_nxt    = w_prod_addr;
                w_wr_data_nxt = w_prod[31:24];
            end
            ST_WR1: begin
                w_wr_en_nxt   = 1'b1;
                w_addr_nxt    = w_prod_addr + ADDR_W'(1);
                w_wr_data_nxt = w_prod[23:16];
            end
            ST_WR2: begin
                w_wr_en_nxt   = 1'b1;
                w_addr_nxt    = w_prod_addr + ADDR_W'(2);
                w_wr_data_nxt = w_prod[15:8];
            end
            ST_WR3: begin
                w_wr_en_nxt   = 1'b1;
                w_addr_nxt    = w_prod_addr + ADDR_W'(3);
                w_wr_data_nxt = w_prod[7:0];
            end
            ST_DONE:  w_done_nxt = 1'b1;
            default:  ;
        endcase
    end

    assign done       = r_done;
    assign dm_wr_en   = r_wr_en;
    assign dm_addr    = r_addr;
    assign dm_wr_data = r_wr_data;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: expected product writes are queued at
// launch and a negedge monitor compares every memory write against the queue.
module tb_mul_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] dm_addr;
    logic [7:0] dm_rd_data;
    logic       dm_wr_en;
    logic [7:0] dm_wr_data;

    logic [7:0]  img [0:127];
    logic [7:0]  mem [0:255];
    logic        load;
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          n_writes = 0;

    always #5 clk = ~clk;

    mul_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .dm_wr_en   (dm_wr_en),
        .dm_wr_data (dm_wr_data)
    );

    assign dm_rd_data = mem[dm_addr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 128; i++) mem[i] <= img[i];
        end else if (dm_wr_en) begin
            mem[dm_addr] <= dm_wr_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] model(input int j);
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [31:0] p;
        a = {img[4*j], img[4*j+1]};
        b = {img[4*j+2], img[4*j+3]};
        p = b * a;
        return p;
    endfunction

    function automatic logic [31:0] mem_word(input int j);
        return {mem[64+4*j], mem[65+4*j], mem[66+4*j], mem[67+4*j]};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 8'h00;
        for (int i = 64; i < 128; i++) img[i] = 8'hAA;
    endtask

    task automatic rand_img();
        clear_img();
        for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    endtask

    task automatic set_pair(input int j, input logic [15:0] a, input logic [15:0] b);
        img[4*j]   = a[15:8];
        img[4*j+1] = a[7:0];
        img[4*j+2] = b[15:8];
        img[4*j+3] = b[7:0];
    endtask

    task automatic do_load();
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic push_writes(input int n_bytes);
        logic [31:0] w;
        for (int i = 0; i < n_bytes; i++) begin
            w = model(i / 4);
            exp_q.push_back({8'(64 + i), w[31 - 8*(i % 4) -: 8]});
        end
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done not seen within 3000 cycles");
        end
    endtask

    task automatic wait_write(input logic [7:0] addr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (dm_wr_en && dm_addr == addr) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: no write to %0d within 1000 cycles", addr);
        end
    endtask

    task automatic check_products(input int n_full);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("product_%0d", j), mem_word(j), (j < n_full) ? model(j) : 32'hAAAAAAAA);
        end
    endtask

    // Monitor: every DUT write must be the next queued expectation
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (dm_wr_en) begin
                n_writes++;
                chk("wr_addr_range", 32'(dm_addr >= 8'd64), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: write addr %0d data %h, required no write", dm_addr, dm_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_write", {16'd0, dm_addr, dm_wr_data}, {16'd0, e});
                end
            end
        end
    end

    initial begin
        int n;
        int nw;
        reset = 1'b1;
        start = 1'b0;
        load  = 1'b0;
        clear_img();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(dm_wr_en), 32'd0);
        chk("rst_addr", 32'(dm_addr), 32'd0);
        chk("rst_wr_data", 32'(dm_wr_data), 32'd0);
        reset = 1'b0;

        // 1: ordinary run, 3 * -5 = -15
        clear_img();
        set_pair(0, 16'd3, 16'hFFFB);
        do_load();
        push_writes(64);
        launch();
        wait_done(n);
        chk("t1_latency", 32'(n), 32'd417);
        chk("t1_prod0", mem_word(0), 32'hFFFFFFF1);
        check_products(16);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: arithmetic extremes
        clear_img();
        set_pair(0, 16'h8000, 16'h8000);
        set_pair(1, 16'h7FFF, 16'h8000);
        set_pair(15, 16'hFFFF, 16'hFFFF);
        do_load();
        push_writes(64);
        launch();
        wait_done(n);
        chk("t2_latency", 32'(n), 32'd417);
        chk("t2_min_min", mem_word(0), 32'h40000000);
        chk("t2_max_min", mem_word(1), 32'hC0008000);
        chk("t2_m1_m1", mem_word(15), 32'h00000001);
        chk("t2_zero", mem_word(7), 32'h00000000);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: random runs with re-launch from DONE
        for (int r = 0; r < 10; r++) begin
            rand_img();
            do_load();
            push_writes(64);
            start = 1'b1;
            @(posedge clk);
            #1;
            chk("t3_done_clear", 32'(done), 32'd0);
            start = 1'b0;
            wait_done(n);
            repeat (5) @(posedge clk);
            #1;
            chk("t3_done_hold", 32'(done), 32'd1);
            check_products(16);
            chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // 4: abort during pair 5 multiply
        rand_img();
        do_load();
        push_writes(20);
        launch();
        wait_write(8'd83);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_wr_en", 32'(dm_wr_en), 32'd0);
        chk("t4_addr", 32'(dm_addr), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check_products(5);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset lands on the edge that would enter WR2 of pair 3
        rand_img();
        do_load();
        push_writes(14);
        launch();
        wait_write(8'd77);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_wr_en", 32'(dm_wr_en), 32'd0);
        chk("t5_addr", 32'(dm_addr), 32'd0);
        chk("t5_wr_data", 32'(dm_wr_data), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_mem77", 32'(mem[77]), 32'(model(3) >> 16) & 32'hFF);
        chk("t5_mem78", 32'(mem[78]), 32'hAA);
        chk("t5_mem79", 32'(mem[79]), 32'hAA);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        push_writes(64);
        launch();
        wait_done(n);
        chk("t5_latency", 32'(n), 32'd417);
        check_products(16);

        // 6: no launch without a prior high start
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        nw = n_writes;
        repeat (1000) @(posedge clk);
        #1;
        chk("t6_no_done", 32'(done), 32'd0);
        chk("t6_no_writes", 32'(n_writes - nw), 32'd0);
        rand_img();
        do_load();
        push_writes(64);
        launch();
        wait_done(n);
        chk("t6_latency", 32'(n), 32'd417);
        check_products(16);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
